// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the digit-serial adder.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to cover the operand width.
    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder, chained DIGIT-wide by serial_adder.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y, carryin -> sum, carryout.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic carryin,
    output logic sum,
    output logic carryout
);

    assign sum      = x ^ y ^ carryin;
    assign carryout = (x & y) | (carryin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands DIGIT bits per cycle with a registered carry.
// Latency: WIDTH/DIGIT cycles from accept to done_valid; one operation in flight.
// Backpressure: start_ready only in IDLE; result held in DONE until done_ready.
// Ports: clk, rst_n (async active-low); start_valid/start_ready with a, b, carry_in
// (and sub when SERIAL_ADDER_SUB_EN is defined); done_valid/done_ready with sum,
// carry_out, overflow.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int NDIG  = digit_count(WIDTH, DIGIT);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT:0]     c;
    logic [DIGIT-1:0]   dsum;
    logic [WIDTH-1:0]   sum_shift;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;
    logic               accept;
    logic               last;

    // Subtraction is a + ~b + 1: invert B once at capture and force the carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : carry_in;
`else
    assign b_load = b;
    assign c_load = carry_in;
`endif

    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);
    assign accept      = start_valid && start_ready;
    assign last        = (state == RUN) && (cnt == LAST_DIG);

    // Digit-wide ripple chain fed by the registered carry.
    assign c[0] = carry;
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        full_adder_cell u_fa (
            .x        (a_sh[gi]),
            .y        (b_sh[gi]),
            .carryin  (c[gi]),
            .sum      (dsum[gi]),
            .carryout (c[gi+1])
        );
    end

    // New digits enter at the MSB so that after NDIG shifts bit 0 is in place.
    if (WIDTH == DIGIT) begin : g_one_digit
        assign sum_shift = dsum;
    end else begin : g_multi_digit
        assign sum_shift = {dsum, sum[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid) state_nxt = RUN;
            RUN:     if (last)        state_nxt = DONE;
            DONE:    if (done_ready)  state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b_load;
                carry <= c_load;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                carry <= c[DIGIT];
                sum   <= sum_shift;
                cnt   <= last ? '0 : cnt + CNT_W'(1);
                if (last) begin
                    carry_out <= c[DIGIT];
                    // On the last digit c[DIGIT-1] is the carry into the MSB.
                    overflow  <= c[DIGIT] ^ c[DIGIT-1];
                end
            end
        end
    end

endmodule
